usb_fs_rx_phy: RTL and testbench

- Full-speed USB receive front-end that consumes the raw D+/D- pad inputs (mprj_io[12]/[11]) and produces decoded packet bytes for the USB device core.
- Synchronises the pads, recovers the bit clock by oversampling, detects SYNC, decodes NRZI, removes stuffed bits and detects EOP.
- Sits directly downstream of the pads and upstream of the packet/PID layer.

---
 rtl/usb_fs_rx_phy.sv | 243 ++++++++++++++++++++++++
 tb/tb_usb_fs_rx_phy.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front-end: pad synchroniser, oversampling clock
// recovery, SYNC detection, NRZI decode, bit unstuffing and EOP detection.
//
// Valid/ready note: this block has no backpressure. Every output is a
// registered level or a one-cycle pulse, and downstream logic must accept
// each rx_valid/rx_sop/rx_eop/rx_err pulse in the cycle it is asserted.
module usb_fs_rx_phy #(
    parameter int OVERSAMPLE   = 4,
    parameter int SYNC_TIMEOUT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pad_dp,
    input  logic       pad_dn,
    input  logic       tx_active,
    output logic       rx_active,
    output logic       rx_sop,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop,
    output logic       rx_err
);
    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int HW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [PW-1:0] SAMPLE_PH = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] LAST_PH   = PW'(OVERSAMPLE - 1);
    localparam logic [HW-1:0] HUNT_LAST = HW'(SYNC_TIMEOUT - 1);

    // Line states as {dp, dn}
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // SYNC pattern K J K J K J K K, oldest symbol in the MSB, 1 = K
    localparam logic [7:0] SYNC_PAT = 8'hAB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_HUNT,
        ST_DATA,
        ST_EOP,
        ST_ERR_WAIT
    } state_t;

    logic [1:0]    dp_sync, dn_sync;
    logic [1:0]    line, line_q;
    logic [PW-1:0] phase_q, phase_cur;
    logic          sample;

    state_t        state, state_n;
    logic [6:0]    sync_sr, sync_sr_n;
    logic [7:0]    sync_shift;
    logic [HW-1:0] hunt_cnt, hunt_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [2:0]    ones_cnt, ones_cnt_n;
    logic          prev_k, prev_k_n;
    logic [6:0]    data_sr, data_sr_n;
    logic [1:0]    se0_cnt, se0_cnt_n;
    logic          j_cnt, j_cnt_n;
    logic          nrzi_bit;
    logic [7:0]    rx_data_n;
    logic          sop_n, valid_n, eop_n, err_n;

    // Line decode and recovered bit strobe; a line change counts as phase 0
    always_comb begin
        line      = {dp_sync[1], dn_sync[1]};
        phase_cur = (line != line_q) ? '0 : phase_q;
        sample    = !tx_active && (phase_cur == SAMPLE_PH);
    end

    // Two-flop pad synchronisers and the free-running bit phase counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_sync <= 2'b11;
            dn_sync <= 2'b00;
            line_q  <= LS_J;
            phase_q <= '0;
        end else begin
            dp_sync <= {dp_sync[0], pad_dp};
            dn_sync <= {dn_sync[0], pad_dn};
            line_q  <= line;
            if (tx_active)
                phase_q <= '0;
            else
                phase_q <= (phase_cur == LAST_PH) ? '0 : phase_cur + PW'(1);
        end
    end

    // Receive FSM next-state, datapath and pulse generation
    always_comb begin
        state_n    = state;
        sync_sr_n  = sync_sr;
        hunt_cnt_n = hunt_cnt;
        bit_cnt_n  = bit_cnt;
        ones_cnt_n = ones_cnt;
        prev_k_n   = prev_k;
        data_sr_n  = data_sr;
        se0_cnt_n  = se0_cnt;
        j_cnt_n    = j_cnt;
        rx_data_n  = rx_data;
        sop_n      = 1'b0;
        valid_n    = 1'b0;
        eop_n      = 1'b0;
        err_n      = 1'b0;
        sync_shift = {sync_sr, line == LS_K};
        nrzi_bit   = ((line == LS_K) == prev_k);

        case (state)
            ST_IDLE: begin
                if (sample && line == LS_K) begin
                    state_n    = ST_SYNC_HUNT;
                    sync_sr_n  = 7'h01;
                    hunt_cnt_n = '0;
                end
            end
            ST_SYNC_HUNT: begin
                if (sample) begin
                    if (line == LS_SE0 || line == LS_SE1) begin
                        state_n = ST_IDLE;
                    end else if (sync_shift == SYNC_PAT) begin
                        state_n    = ST_DATA;
                        sop_n      = 1'b1;
                        bit_cnt_n  = '0;
                        ones_cnt_n = '0;
                        prev_k_n   = 1'b1;
                    end else if (hunt_cnt == HUNT_LAST) begin
                        state_n = ST_IDLE;
                    end else begin
                        sync_sr_n  = sync_shift[6:0];
                        hunt_cnt_n = hunt_cnt + HW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (line == LS_SE1) begin
                        state_n = ST_ERR_WAIT;
                        err_n   = 1'b1;
                        j_cnt_n = 1'b0;
                    end else if (line == LS_SE0) begin
                        // A stuff bit still owed at SE0 is not an error
                        if (bit_cnt != 3'd0) begin
                            state_n = ST_ERR_WAIT;
                            err_n   = 1'b1;
                            j_cnt_n = 1'b0;
                        end else begin
                            state_n   = ST_EOP;
                            se0_cnt_n = 2'd1;
                        end
                    end else begin
                        prev_k_n = (line == LS_K);
                        if (ones_cnt == 3'd6) begin
                            // Stuff bit: discarded, must be a 0
                            ones_cnt_n = '0;
                            if (nrzi_bit) begin
                                state_n = ST_ERR_WAIT;
                                err_n   = 1'b1;
                                j_cnt_n = 1'b0;
                            end
                        end else begin
                            ones_cnt_n = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                            data_sr_n  = {nrzi_bit, data_sr[6:1]};
                            if (bit_cnt == 3'd7) begin
                                rx_data_n = {nrzi_bit, data_sr};
                                valid_n   = 1'b1;
                                bit_cnt_n = 3'd0;
                            end else begin
                                bit_cnt_n = bit_cnt + 3'd1;
                            end
                        end
                    end
                end
            end
            ST_EOP: begin
                if (sample) begin
                    if (line == LS_J) begin
                        state_n = ST_IDLE;
                        eop_n   = 1'b1;
                    end else if (line == LS_SE0 && se0_cnt != 2'd3) begin
                        se0_cnt_n = se0_cnt + 2'd1;
                    end else begin
                        state_n = ST_ERR_WAIT;
                        err_n   = 1'b1;
                        j_cnt_n = 1'b0;
                    end
                end
            end
            ST_ERR_WAIT: begin
                if (sample) begin
                    if (line == LS_J) begin
                        if (j_cnt) state_n = ST_IDLE;
                        j_cnt_n = 1'b1;
                    end else begin
                        j_cnt_n = 1'b0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Local transmit owns the bus: drop the packet without a verdict
        if (tx_active) state_n = ST_IDLE;
    end

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sync_sr  <= '0;
            hunt_cnt <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            prev_k   <= 1'b0;
            data_sr  <= '0;
            se0_cnt  <= '0;
            j_cnt    <= 1'b0;
            rx_data  <= 8'h00;
            rx_sop   <= 1'b0;
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_n;
            sync_sr  <= sync_sr_n;
            hunt_cnt <= hunt_cnt_n;
            bit_cnt  <= bit_cnt_n;
            ones_cnt <= ones_cnt_n;
            prev_k   <= prev_k_n;
            data_sr  <= data_sr_n;
            se0_cnt  <= se0_cnt_n;
            j_cnt    <= j_cnt_n;
            rx_data  <= rx_data_n;
            rx_sop   <= sop_n;
            rx_valid <= valid_n;
            rx_eop   <= eop_n;
            rx_err   <= err_n;
        end
    end

    assign rx_active = (state == ST_DATA) || (state == ST_EOP);

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Directed bench for usb_fs_rx_phy: an NRZI/bit-stuffing line encoder drives
// the pads, a monitor scores received bytes against an expected queue and
// counts sop/eop/err pulses per scenario.
module tb_usb_fs_rx_phy;
    localparam int OS = 4;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       pad_dp, pad_dn;
    logic       tx_active;
    logic       rx_active, rx_sop, rx_valid, rx_eop, rx_err;
    logic [7:0] rx_data;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    int         sop_cnt, eop_cnt, err_cnt;
    int         cyc = 0;
    int         last_valid_cyc = 0;

    logic [1:0] cur_line;
    int         ones;
    bit         jitter = 1'b0;
    bit         jw = 1'b0;
    bit         stuff_en = 1'b1;

    // Clock
    always #5 clk = ~clk;

    usb_fs_rx_phy #(.OVERSAMPLE(OS), .SYNC_TIMEOUT(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_dp    (pad_dp),
        .pad_dn    (pad_dn),
        .tx_active (tx_active),
        .rx_active (rx_active),
        .rx_sop    (rx_sop),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_eop    (rx_eop),
        .rx_err    (rx_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Monitor: byte scoreboard and pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        logic [31:0] exp_b;
        cyc++;
        if (rx_sop) sop_cnt++;
        if (rx_err) err_cnt++;
        if (rx_valid) begin
            last_valid_cyc = cyc;
            exp_b = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h100;
            check("byte", {24'h0, rx_data}, exp_b);
        end
        if (rx_eop) begin
            eop_cnt++;
            check("eop_valid_excl", {31'h0, rx_valid}, 32'h0);
            check("eop_gap", {31'h0, (cyc - last_valid_cyc) >= OS}, 32'h1);
        end
    end

    // Drivers
    task automatic put_line(input logic [1:0] ls);
        int w;
        w = OS;
        if (jitter) begin
            w  = jw ? 5 : 3;
            jw = !jw;
        end
        {pad_dp, pad_dn} = ls;
        repeat (w) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        if (!b) cur_line = (cur_line == LS_J) ? LS_K : LS_J;
        put_line(cur_line);
        if (b) begin
            ones++;
            if (ones == 6 && stuff_en) begin
                ones = 0;
                cur_line = (cur_line == LS_J) ? LS_K : LS_J;
                put_line(cur_line);
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_sync();
        cur_line = LS_J;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(b[i]);
    endtask

    task automatic send_eop(input int n_se0);
        repeat (n_se0) put_line(LS_SE0);
        cur_line = LS_J;
        put_line(LS_J);
    endtask

    task automatic idle(input int nbits);
        cur_line = LS_J;
        repeat (nbits) put_line(LS_J);
    endtask

    task automatic start_scn();
        sop_cnt = 0;
        eop_cnt = 0;
        err_cnt = 0;
        exp_q.delete();
    endtask

    task automatic end_scn(input string tag, input int sop, input int eop, input int err);
        idle(10);
        check({tag, "_sop"}, sop_cnt, sop);
        check({tag, "_eop"}, eop_cnt, eop);
        check({tag, "_err"}, err_cnt, err);
        check({tag, "_bytes_left"}, exp_q.size(), 0);
        check({tag, "_active_idle"}, {31'h0, rx_active}, 32'h0);
    endtask

    task automatic in_token(input string tag);
        start_scn();
        exp_q = '{8'h69, 8'h82, 8'h18};
        send_sync();
        send_byte(8'h69, 0, 7);
        send_byte(8'h82, 0, 7);
        send_byte(8'h18, 0, 7);
        send_eop(2);
        end_scn(tag, 1, 1, 0);
    endtask

    // Stimulus
    initial begin
        rst = 1'b1;
        tx_active = 1'b0;
        {pad_dp, pad_dn} = LS_J;
        cur_line = LS_J;
        ones = 0;
        repeat (4) @(negedge clk);
        check("rst_active", {31'h0, rx_active}, 32'h0);
        check("rst_sop",    {31'h0, rx_sop},    32'h0);
        check("rst_valid",  {31'h0, rx_valid},  32'h0);
        check("rst_eop",    {31'h0, rx_eop},    32'h0);
        check("rst_err",    {31'h0, rx_err},    32'h0);
        check("rst_data",   {24'h0, rx_data},   32'h0);
        rst = 1'b0;
        idle(4);

        // Clean IN token
        in_token("in_token");

        // Stuffing inside 0xFF 0xFF
        start_scn();
        exp_q = '{8'hFF, 8'hFF};
        send_sync();
        send_byte(8'hFF, 0, 7);
        send_byte(8'hFF, 0, 7);
        send_eop(2);
        end_scn("stuffed_ff", 1, 1, 0);

        // Seven consecutive ones, then recovery
        start_scn();
        exp_q = '{8'h69};
        send_sync();
        send_byte(8'h69, 0, 7);
        stuff_en = 1'b0;
        send_byte(8'h7F, 0, 6);
        stuff_en = 1'b1;
        idle(4);
        end_scn("seven_ones", 1, 0, 1);
        in_token("after_err");

        // EOP after 5 bits of a byte
        start_scn();
        exp_q = '{8'h69};
        send_sync();
        send_byte(8'h69, 0, 7);
        send_byte(8'h15, 0, 4);
        send_eop(2);
        end_scn("short_byte", 1, 0, 1);

        // Four SE0 symbols
        start_scn();
        exp_q = '{8'h82};
        send_sync();
        send_byte(8'h82, 0, 7);
        send_eop(4);
        end_scn("long_eop", 1, 0, 1);

        // 3/5 clk alternating bit widths
        jitter = 1'b1;
        jw = 1'b0;
        in_token("jitter");
        jitter = 1'b0;

        // tx_active after the first byte
        start_scn();
        exp_q = '{8'h69};
        send_sync();
        send_byte(8'h69, 0, 7);
        send_byte(8'h82, 0, 0);
        check("tx_pre_active", {31'h0, rx_active}, 32'h1);
        tx_active = 1'b1;
        @(negedge clk);
        check("tx_active_drop", {31'h0, rx_active}, 32'h0);
        send_byte(8'h82, 1, 7);
        send_byte(8'h18, 0, 7);
        send_eop(2);
        idle(2);
        tx_active = 1'b0;
        end_scn("tx_cut", 1, 0, 0);
        in_token("after_tx");

        // rst after the second byte
        start_scn();
        exp_q = '{8'h69, 8'h82};
        send_sync();
        send_byte(8'h69, 0, 7);
        send_byte(8'h82, 0, 7);
        send_byte(8'h18, 0, 0);
        check("rst_pre_active", {31'h0, rx_active}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_active", {31'h0, rx_active}, 32'h0);
        check("rst_mid_data",   {24'h0, rx_data},   32'h0);
        send_byte(8'h18, 1, 7);
        send_eop(2);
        idle(2);
        rst = 1'b0;
        end_scn("rst_cut", 1, 0, 0);
        in_token("after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Absolute time bound on the run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
